zeroheti_sba_obi_mgr: RTL and testbench
=======================================

Name: zeroheti_sba_obi_mgr

Overview:
- Manager-side bridge for the debug module's system-bus-access (SBA) master port.
- Converts the debug module's req/gnt/rvalid handshake into a compliant OBI manager transaction on the zeroHETI interconnect.
- Supports one outstanding transaction, with a tag on aid, response filtering by rid, and a timeout that reports a bus error to the debug module.
- Sits in the debug wrapper between the debug module master port and the SBA crossbar port.

Parameters:
- AddrWidth, 32, address width on both sides.
- DataWidth, 32, data width; byte enable is DataWidth/8.
- IdWidth, 1, OBI aid/rid width; transaction tag width.
- TimeoutCycles, 1024, cycles from acceptance before an abort; 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- sba_req_i  in  1  debug module request.
- sba_addr_i  in  AddrWidth  request address.
- sba_we_i  in  1  write enable.
- sba_wdata_i  in  DataWidth  write data.
- sba_be_i  in  DataWidth/8  byte enables.
- sba_gnt_o  out  1  one-cycle grant pulse to the debug module.
- sba_rvalid_o  out  1  one-cycle response pulse.
- sba_rdata_o  out  DataWidth  response data.
- sba_err_o  out  1  subordinate error; valid with sba_rvalid_o.
- sba_other_err_o  out  1  timeout error; valid with sba_rvalid_o.
- obi_req_o  out  1  OBI request.
- obi_gnt_i  in  1  OBI grant.
- obi_addr_o  out  AddrWidth  OBI address.
- obi_we_o  out  1  OBI write enable.
- obi_be_o  out  DataWidth/8  OBI byte enables.
- obi_wdata_o  out  DataWidth  OBI write data.
- obi_aid_o  out  IdWidth  transaction tag.
- obi_rvalid_i  in  1  OBI response valid.
- obi_rdata_i  in  DataWidth  OBI read data.
- obi_rid_i  in  IdWidth  response tag.
- obi_err_i  in  1  OBI response error.

Behaviour:
- Interface: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values:
  - all outputs 0;
  - state IDLE;
  - tag 0;
  - timeout counter 0;
  - address/data/control registers 0.
- All outputs are registered; no combinational path from input to output.
- FSM states: IDLE, ADDR, RESP, ABORT.
- IDLE:
  - On sba_req_i=1 at cycle c: latch addr/we/wdata/be; tag <= tag+1 (wraps); counter <= 0; go to ADDR.
  - obi_req_o=1 from c+1, with obi_aid_o = new tag.
  - Any obi_rvalid_i seen in IDLE is ignored (stale response).
- ADDR:
  - obi_req_o and all OBI address-phase outputs are held stable until grant.
  - obi_gnt_i=1 at cycle k: obi_req_o=0 at k+1; sba_gnt_o=1 for exactly cycle k+1; counter <= 0; go to RESP.
  - obi_rvalid_i is ignored in ADDR.
- RESP:
  - obi_rvalid_i=1 with obi_rid_i==tag at cycle m: at m+1, sba_rvalid_o=1 for one cycle, sba_rdata_o=obi_rdata_i (0 for writes is not forced; pass through), sba_err_o=obi_err_i, sba_other_err_o=0; go to IDLE.
  - A new request may be accepted at m+1.
  - rvalid with a mismatched rid is dropped silently.
- Timeout (TimeoutCycles>0):
  - The counter increments each cycle in ADDR and RESP.
  - Firing in RESP when counter==TimeoutCycles-1 and no matching rvalid: next cycle sba_rvalid_o=1, sba_other_err_o=1, sba_err_o=0, sba_rdata_o=0; go to IDLE.
  - Firing in ADDR with no gnt: next cycle sba_gnt_o=1; the cycle after, sba_rvalid_o=1 with sba_other_err_o=1, rdata 0; go to ABORT.
- ABORT:
  - obi_req_o stays 1 with unchanged payload, for OBI compliance.
  - On obi_gnt_i, drop req next cycle and go to IDLE.
  - The later response is discarded by the rid mismatch or the IDLE ignore rule.
  - sba_req_i is not accepted in ABORT.
- Simultaneous events:
  - gnt in the same cycle as an ADDR timeout: gnt wins, normal path.
  - Matching rvalid in the same cycle as a RESP timeout: rvalid wins, real data and err.
- Known limitation: with IdWidth=1, a stale response older than one subsequent transaction aliases. IdWidth>=2 removes this for two aborted transactions.
- Reset mid-transaction: everything returns to reset values immediately, including obi_req_o=0.

Test Plan:
- Read: sba_req addr 0x0000_1000; gnt 2 cycles later; rvalid rid=1, rdata 0xCAFEF00D, err 0 -> obi_aid_o=1; sba_gnt_o pulse 1 cycle after gnt; sba_rvalid_o 1 cycle after rvalid with 0xCAFEF00D; err=0, other_err=0.
- Write with error: write 0xA5A5A5A5 with be=4'b0011; rvalid err=1 -> obi_we_o=1, be=0011, wdata held until gnt; sba_err_o=1 with rvalid.
- Response timeout (TimeoutCycles=8): gnt immediately, no rvalid -> sba_rvalid_o with other_err=1, rdata 0; next transaction aid=2; a late rvalid rid=1 during it is dropped and only rid=2 is returned.
- Address timeout (TimeoutCycles=8): gnt withheld 20 cycles -> sba_gnt_o then sba_rvalid_o/other_err at cycle ~9; obi_req_o stays high until the gnt at cycle 20; state IDLE afterwards; stale rvalid ignored.
- Races: gnt asserted exactly at the ADDR timeout cycle, and matching rvalid exactly at the RESP timeout cycle -> normal completion, other_err=0.
- Reset: assert rst_ni low during RESP -> all outputs 0 asynchronously; a new transaction after reset uses aid=1.

Source files
------------

// File: rtl/zeroheti_sba_obi_mgr.sv
// Bridge from the debug module SBA master port (req/gnt/rvalid) to an OBI
// manager port. One outstanding transaction, tagged on aid, with responses
// filtered by rid and an optional timeout that reports other_err.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   sba_req_i .. sba_be_i    debug module request and payload
//   sba_gnt_o, sba_rvalid_o  one-cycle grant / response pulses
//   sba_rdata_o, sba_err_o,
//   sba_other_err_o          response data, subordinate error, timeout error
//   obi_req_o .. obi_aid_o   OBI address phase (held until granted)
//   obi_gnt_i                OBI grant
//   obi_rvalid_i .. obi_err_i OBI response phase
module zeroheti_sba_obi_mgr #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned IdWidth       = 1,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   sba_req_i,
  input  logic [AddrWidth-1:0]   sba_addr_i,
  input  logic                   sba_we_i,
  input  logic [DataWidth-1:0]   sba_wdata_i,
  input  logic [DataWidth/8-1:0] sba_be_i,
  output logic                   sba_gnt_o,
  output logic                   sba_rvalid_o,
  output logic [DataWidth-1:0]   sba_rdata_o,
  output logic                   sba_err_o,
  output logic                   sba_other_err_o,
  output logic                   obi_req_o,
  input  logic                   obi_gnt_i,
  output logic [AddrWidth-1:0]   obi_addr_o,
  output logic                   obi_we_o,
  output logic [DataWidth/8-1:0] obi_be_o,
  output logic [DataWidth-1:0]   obi_wdata_o,
  output logic [IdWidth-1:0]     obi_aid_o,
  input  logic                   obi_rvalid_i,
  input  logic [DataWidth-1:0]   obi_rdata_i,
  input  logic [IdWidth-1:0]     obi_rid_i,
  input  logic                   obi_err_i
);

  localparam int unsigned BeWidth  = DataWidth / 8;
  localparam int unsigned CntWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);
  localparam bit TimeoutEn = (TimeoutCycles != 0);

  typedef enum logic [1:0] {IDLE, ADDR, RESP, ABORT} state_e;

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [IdWidth-1:0]    tag_q, tag_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic                  we_q, we_d;
  logic [BeWidth-1:0]    be_q, be_d;
  logic [DataWidth-1:0]  wdata_q, wdata_d;
  logic                  req_q, req_d;
  logic                  gnt_q, gnt_d;
  logic                  rvalid_q, rvalid_d;
  logic [DataWidth-1:0]  rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  oerr_q, oerr_d;
  logic                  timeout;
  logic                  rsp_match;

  assign timeout   = TimeoutEn && (cnt_q == CntLast);
  assign rsp_match = obi_rvalid_i && (obi_rid_i == tag_q);

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tag_d    = tag_q;
    addr_d   = addr_q;
    we_d     = we_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    gnt_d    = 1'b0;
    rvalid_d = 1'b0;
    rdata_d  = '0;
    err_d    = 1'b0;
    oerr_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sba_req_i) begin
          addr_d  = sba_addr_i;
          we_d    = sba_we_i;
          be_d    = sba_be_i;
          wdata_d = sba_wdata_i;
          tag_d   = tag_q + IdWidth'(1);
          cnt_d   = '0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        cnt_d = cnt_q + CntWidth'(1);
        // A grant in the timeout cycle still completes normally
        if (obi_gnt_i) begin
          gnt_d   = 1'b1;
          cnt_d   = '0;
          state_d = RESP;
        end else if (timeout) begin
          gnt_d   = 1'b1;
          state_d = ABORT;
        end
      end
      RESP: begin
        cnt_d = cnt_q + CntWidth'(1);
        if (rsp_match) begin
          rvalid_d = 1'b1;
          rdata_d  = obi_rdata_i;
          err_d    = obi_err_i;
          state_d  = IDLE;
        end else if (timeout) begin
          rvalid_d = 1'b1;
          oerr_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      ABORT: begin
        // Error response follows the abort grant pulse by one cycle
        rvalid_d = gnt_q;
        oerr_d   = gnt_q;
        if (obi_gnt_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    req_d = (state_d == ADDR) || (state_d == ABORT);
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tag_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      req_q    <= 1'b0;
      gnt_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      oerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tag_q    <= tag_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      req_q    <= req_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      oerr_q   <= oerr_d;
    end
  end

  assign sba_gnt_o       = gnt_q;
  assign sba_rvalid_o    = rvalid_q;
  assign sba_rdata_o     = rdata_q;
  assign sba_err_o       = err_q;
  assign sba_other_err_o = oerr_q;
  assign obi_req_o       = req_q;
  assign obi_addr_o      = addr_q;
  assign obi_we_o        = we_q;
  assign obi_be_o        = be_q;
  assign obi_wdata_o     = wdata_q;
  assign obi_aid_o       = tag_q;

endmodule

// File: tb/tb_zeroheti_sba_obi_mgr.sv
// Bench for zeroheti_sba_obi_mgr: transaction-level reference model that
// predicts, per transaction, the cycle of every handshake pulse from the
// grant/response delays and the timeout length.
module tb_zeroheti_sba_obi_mgr;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned IW = 2;
  localparam int          T  = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          sba_req_i;
  logic [AW-1:0] sba_addr_i;
  logic          sba_we_i;
  logic [DW-1:0] sba_wdata_i;
  logic [BW-1:0] sba_be_i;
  logic          sba_gnt_o;
  logic          sba_rvalid_o;
  logic [DW-1:0] sba_rdata_o;
  logic          sba_err_o;
  logic          sba_other_err_o;
  logic          obi_req_o;
  logic          obi_gnt_i;
  logic [AW-1:0] obi_addr_o;
  logic          obi_we_o;
  logic [BW-1:0] obi_be_o;
  logic [DW-1:0] obi_wdata_o;
  logic [IW-1:0] obi_aid_o;
  logic          obi_rvalid_i;
  logic [DW-1:0] obi_rdata_i;
  logic [IW-1:0] obi_rid_i;
  logic          obi_err_i;

  zeroheti_sba_obi_mgr #(
    .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .TimeoutCycles(T)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .sba_req_i(sba_req_i), .sba_addr_i(sba_addr_i), .sba_we_i(sba_we_i),
    .sba_wdata_i(sba_wdata_i), .sba_be_i(sba_be_i),
    .sba_gnt_o(sba_gnt_o), .sba_rvalid_o(sba_rvalid_o), .sba_rdata_o(sba_rdata_o),
    .sba_err_o(sba_err_o), .sba_other_err_o(sba_other_err_o),
    .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
    .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
    .obi_aid_o(obi_aid_o), .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i),
    .obi_rid_i(obi_rid_i), .obi_err_i(obi_err_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [IW-1:0] exp_tag;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_sba"}, 64'({sba_gnt_o, sba_rvalid_o, sba_err_o, sba_other_err_o}), 64'd0);
    check({name, "_rdata"}, 64'(sba_rdata_o), 64'd0);
    check({name, "_obi"}, 64'({obi_req_o, obi_we_o, obi_be_o, obi_aid_o}), 64'd0);
    check({name, "_addr"}, 64'(obi_addr_o), 64'd0);
    check({name, "_wdata"}, 64'(obi_wdata_o), 64'd0);
  endtask

  // Random response-channel activity that the DUT must ignore
  task automatic noise_rsp(input bit force_mismatch, input logic [IW-1:0] tg);
    obi_rdata_i = $urandom;
    obi_err_i   = 1'($urandom_range(0, 1));
    obi_rvalid_i = ($urandom_range(0, 3) == 0);
    obi_rid_i   = force_mismatch ? tg - IW'(1) : IW'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      check("idle_req", 64'(obi_req_o), 64'd0);
      check("idle_sba", 64'({sba_gnt_o, sba_rvalid_o}), 64'd0);
      sba_req_i = 1'b0;
      obi_gnt_i = 1'b0;
      noise_rsp(1'b0, exp_tag);
    end
  endtask

  // One SBA transaction. gd: cycles from first obi_req until gnt.
  // d: cycles from first RESP cycle until the response (>= T means none).
  task automatic txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                     input logic [BW-1:0] be, input int gd, input int d,
                     input logic rerr, input logic [DW-1:0] rd);
    int g, sg, rvr, last;
    bit ato, norm;
    logic [IW-1:0] tg;
    exp_tag = exp_tag + IW'(1);
    tg   = exp_tag;
    g    = 1 + gd;
    ato  = (gd >= T);
    norm = !ato && (d <= T - 1);
    sg   = ato ? T + 1 : g + 1;
    rvr  = ato ? T + 2 : (norm ? g + 2 + d : g + 1 + T);
    last = (rvr > g + 1) ? rvr : g + 1;
    for (int r = 0; r <= last; r++) begin
      @(negedge clk_i);
      check("obi_req", 64'(obi_req_o), 64'(r >= 1 && r <= g));
      if (r >= 1 && r <= g) begin
        check("obi_addr", 64'(obi_addr_o), 64'(addr));
        check("obi_ctl", 64'({obi_we_o, obi_be_o}), 64'({we, be}));
        check("obi_wdata", 64'(obi_wdata_o), 64'(wdata));
        check("obi_aid", 64'(obi_aid_o), 64'(tg));
      end
      check("sba_gnt", 64'(sba_gnt_o), 64'(r == sg));
      check("sba_rvalid", 64'(sba_rvalid_o), 64'(r == rvr));
      if (r == rvr) begin
        check("sba_rdata", 64'(sba_rdata_o), norm ? 64'(rd) : 64'd0);
        check("sba_err", 64'(sba_err_o), norm ? 64'(rerr) : 64'd0);
        check("sba_other_err", 64'(sba_other_err_o), 64'(!norm));
      end
      // Drive this cycle's inputs
      if (r == 0) begin
        sba_req_i = 1'b1;
        sba_addr_i = addr; sba_we_i = we; sba_wdata_i = wdata; sba_be_i = be;
      end else begin
        sba_req_i   = ato && r > T && r <= g && ($urandom_range(0, 1) == 1);
        sba_addr_i  = $urandom; sba_we_i = 1'($urandom_range(0, 1));
        sba_wdata_i = $urandom; sba_be_i = BW'($urandom);
      end
      obi_gnt_i = (r == g);
      if (norm && r == g + 1 + d) begin
        obi_rvalid_i = 1'b1; obi_rid_i = tg; obi_rdata_i = rd; obi_err_i = rerr;
      end else begin
        noise_rsp(!ato && r > g && r < rvr, tg);
      end
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    sba_req_i = 1'b0; sba_addr_i = '0; sba_we_i = 1'b0; sba_wdata_i = '0; sba_be_i = '0;
    obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_rdata_i = '0; obi_rid_i = '0; obi_err_i = 1'b0;
    exp_tag = '0;
    repeat (3) @(negedge clk_i);
    check_all_zero("reset");
    rst_ni = 1'b1;

    // Directed: read, write with error, response timeout, address timeout, races
    txn(1'b0, 32'h0000_1000, 32'h0, 4'hF, 2, 1, 1'b0, 32'hCAFE_F00D);
    idle_cycles(2);
    txn(1'b1, 32'h0000_2004, 32'hA5A5_A5A5, 4'b0011, 3, 0, 1'b1, 32'h1234_5678);
    txn(1'b0, 32'h0000_3000, 32'h0, 4'hF, 0, T, 1'b0, 32'hDEAD_BEEF);
    txn(1'b0, 32'h0000_3004, 32'h0, 4'hF, 1, 2, 1'b0, 32'h0BAD_CAFE);
    txn(1'b1, 32'h0000_4000, 32'h5555_AAAA, 4'b1100, 19, 0, 1'b0, 32'h0);
    idle_cycles(4);
    txn(1'b0, 32'h0000_5000, 32'h0, 4'hF, T - 1, T - 1, 1'b0, 32'h1357_9BDF);
    txn(1'b0, 32'h0000_5004, 32'h0, 4'hF, T, 0, 1'b0, 32'h0);

    // Random transactions
    for (int i = 0; i < 30; i++) begin
      txn(1'($urandom_range(0, 1)), $urandom, $urandom, BW'($urandom),
          int'($urandom_range(0, T + 3)), int'($urandom_range(0, T + 2)),
          1'($urandom_range(0, 1)), $urandom);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    // Reset asserted while waiting for a response
    @(negedge clk_i);
    sba_req_i = 1'b1; sba_addr_i = 32'h0000_6000; sba_we_i = 1'b1;
    sba_wdata_i = 32'hFFFF_0000; sba_be_i = 4'hF;
    @(negedge clk_i);
    sba_req_i = 1'b0; obi_gnt_i = 1'b1; obi_rvalid_i = 1'b0;
    @(negedge clk_i);
    obi_gnt_i = 1'b0;
    check("pre_reset_gnt", 64'(sba_gnt_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    exp_tag = '0;
    txn(1'b0, 32'h0000_7000, 32'h0, 4'hF, 1, 1, 1'b0, 32'h7777_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
